// File: rtl/pitch_pkg.sv
// Shared types and constants for the pitch-detection path.
// Frame geometry, sample/word formats and the debug encoding of the frame writer.
package pitch_pkg;

  localparam int N_SAMPLES = 64;
  localparam int SAMPLE_W  = 12;
  localparam int OUT_W     = 16;

  typedef logic [SAMPLE_W-1:0]         mic_sample_t;
  typedef logic signed [OUT_W-1:0]     fft_word_t;
  typedef fft_word_t [N_SAMPLES-1:0]   frame_t;

  // Writer condition, derived from the full flag of the bank being written.
  typedef enum logic {
    W_FILL  = 1'b0,
    W_STALL = 1'b1
  } wr_state_e;

endpackage

// File: rtl/sample_bank.sv
// One frame bank: N words, single write port, whole array visible on the output.
// Cleared asynchronously so a freshly reset buffer presents all-zero frames.
module sample_bank
  import pitch_pkg::*;
#(
  parameter int N = N_SAMPLES,
  parameter int W = OUT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [$clog2(N)-1:0]   idx,
  input  logic [W-1:0]           wdata,
  output logic [N-1:0][W-1:0]    words
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words <= '0;
    end else if (we) begin
      words[idx] <= wdata;
    end
  end

endmodule

// File: rtl/mic_frame_buffer.sv
// Microphone front end: decimate, remove DC offset, and double-buffer samples
// into frames handed to the FFT stage under a valid/ready handshake.
module mic_frame_buffer #(
  parameter int N_SAMPLES = pitch_pkg::N_SAMPLES,
  parameter int SAMPLE_W  = pitch_pkg::SAMPLE_W,
  parameter int OUT_W     = pitch_pkg::OUT_W,
  parameter int DECIM     = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              mic_valid,
  input  logic [SAMPLE_W-1:0]               mic_data,
  input  logic                              frame_ready,
  output logic                              frame_valid,
  output logic [N_SAMPLES-1:0][OUT_W-1:0]   frame_data,
  output logic [15:0]                       frame_count,
  output logic                              overrun,
  output pitch_pkg::wr_state_e              wr_state
);

  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

  logic [DEC_W-1:0]              dec_cnt;
  logic                          keep;
  logic                          wr_bank;
  logic                          rd_bank;
  logic [IDX_W-1:0]              wr_idx;
  logic [1:0]                    full;
  logic [1:0]                    full_next;
  logic                          wr_en;
  logic                          bank_done;
  logic                          hs;
  logic [SAMPLE_W-1:0]           s;
  logic [OUT_W-1:0]              word;
  logic [N_SAMPLES-1:0][OUT_W-1:0] bank0_words;
  logic [N_SAMPLES-1:0][OUT_W-1:0] bank1_words;

  // Offset-binary to two's complement: flipping the MSB subtracts midscale.
  assign s    = {~mic_data[SAMPLE_W-1], mic_data[SAMPLE_W-2:0]};
  assign word = OUT_W'($signed(s));

  assign keep      = mic_valid && (dec_cnt == DEC_LAST);
  assign wr_en     = keep && !full[wr_bank];
  assign bank_done = wr_en && (wr_idx == LAST_IDX);

  // Handshake: a frame transfers on any rising edge where frame_valid and
  // frame_ready are both high; frame_valid never drops without a transfer
  // except on reset, and frame_ready alone has no effect.
  assign frame_valid = full[rd_bank];
  assign hs          = frame_valid && frame_ready;
  assign frame_data  = rd_bank ? bank1_words : bank0_words;

  always_comb begin
    full_next = full;
    if (hs) begin
      full_next[rd_bank] = 1'b0;
    end
    // A completing bank is never rd_bank's full bank, so the two updates are disjoint.
    if (bank_done) begin
      full_next[wr_bank] = 1'b1;
    end
  end

  always_comb begin
    wr_state = pitch_pkg::W_FILL;
    if (full[wr_bank]) begin
      wr_state = pitch_pkg::W_STALL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_cnt <= '0;
    end else if (mic_valid) begin
      dec_cnt <= keep ? '0 : dec_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank     <= 1'b0;
      wr_idx      <= '0;
      rd_bank     <= 1'b0;
      full        <= 2'b00;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      full <= full_next;
      if (wr_en) begin
        if (bank_done) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      // A freed bank only accepts samples from the following edge onward.
      if (keep && full[wr_bank]) begin
        overrun <= 1'b1;
      end
      if (hs) begin
        rd_bank     <= ~rd_bank;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  sample_bank #(.N(N_SAMPLES), .W(OUT_W)) u_bank0 (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en && !wr_bank),
    .idx   (wr_idx),
    .wdata (word),
    .words (bank0_words)
  );

  sample_bank #(.N(N_SAMPLES), .W(OUT_W)) u_bank1 (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en && wr_bank),
    .idx   (wr_idx),
    .wdata (word),
    .words (bank1_words)
  );

endmodule

// File: tb/tb_mic_frame_buffer.sv
// Bench for mic_frame_buffer: directed sample streams, expected frames queued
// at issue time and compared by monitors at each frame handshake.
module tb_mic_frame_buffer;
  import pitch_pkg::*;

  localparam int N  = 64;
  localparam int FW = N * 16;

  logic              clk;
  logic              reset;
  logic              mic_valid;
  logic [11:0]       mic_data;
  logic              frame_ready;
  logic              frame_valid;
  logic [N-1:0][15:0] frame_data;
  logic [15:0]       frame_count;
  logic              overrun;
  wr_state_e         wr_state;

  logic              dmic_valid;
  logic [11:0]       dmic_data;
  logic              dframe_ready;
  logic              dframe_valid;
  logic [N-1:0][15:0] dframe_data;
  logic [15:0]       dframe_count;
  logic              doverrun;
  wr_state_e         dwr_state;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] exp_dec_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  mic_frame_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .mic_valid   (mic_valid),
    .mic_data    (mic_data),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_count (frame_count),
    .overrun     (overrun),
    .wr_state    (wr_state)
  );

  mic_frame_buffer #(.DECIM(4)) dut_dec (
    .clk         (clk),
    .reset       (reset),
    .mic_valid   (dmic_valid),
    .mic_data    (dmic_data),
    .frame_ready (dframe_ready),
    .frame_valid (dframe_valid),
    .frame_data  (dframe_data),
    .frame_count (dframe_count),
    .overrun     (doverrun),
    .wr_state    (dwr_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Checks and model
  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    int first;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      first = 0;
      for (int i = N - 1; i >= 0; i--) begin
        if (act[i*16 +: 16] !== exp[i*16 +: 16]) first = i;
      end
      $display("FAIL %s: word %0d got 0x%04h expected 0x%04h", name, first,
               act[first*16 +: 16], exp[first*16 +: 16]);
    end
  endtask

  function automatic logic [FW-1:0] ramp_frame(input int base, input int step);
    logic [FW-1:0] f;
    int v;
    f = '0;
    for (int i = 0; i < N; i++) begin
      v = base + step * i - 2048;
      f[i*16 +: 16] = 16'(v);
    end
    return f;
  endfunction

  // Monitors: compare the presented frame on every handshake edge
  always @(negedge clk) begin
    if (!reset && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_handshake: frame_count 0x%0h with no frame expected", frame_count);
      end else begin
        check_frame("handshake_frame", frame_data, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && dframe_valid && dframe_ready) begin
      if (exp_dec_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_dec_handshake: frame_count 0x%0h with no frame expected", dframe_count);
      end else begin
        check_frame("dec_handshake_frame", dframe_data, exp_dec_q.pop_front());
      end
    end
  end

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int v);
    mic_valid = 1'b1;
    mic_data  = 12'(v);
    tick();
    mic_valid = 1'b0;
  endtask

  task automatic dstrobe(input int v);
    dmic_valid = 1'b1;
    dmic_data  = 12'(v);
    tick();
    dmic_valid = 1'b0;
  endtask

  task automatic handshake();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Stimulus
  initial begin
    logic [FW-1:0] f;
    reset        = 1'b1;
    mic_valid    = 1'b1;
    mic_data     = 12'h5A5;
    frame_ready  = 1'b1;
    dmic_valid   = 1'b1;
    dmic_data    = 12'h123;
    dframe_ready = 1'b0;
    tick();
    tick();
    check_val("reset_frame_valid", 32'(frame_valid), 32'd0);
    check_val("reset_frame_count", 32'(frame_count), 32'd0);
    check_val("reset_overrun", 32'(overrun), 32'd0);
    check_frame("reset_frame_data", frame_data, '0);
    reset       = 1'b0;
    mic_valid   = 1'b0;
    frame_ready = 1'b0;
    dmic_valid  = 1'b0;

    // Ramp 0..63
    for (int i = 0; i < N - 1; i++) strobe(i);
    check_val("ramp_valid_before_last", 32'(frame_valid), 32'd0);
    strobe(N - 1);
    check_val("ramp_valid_after_last", 32'(frame_valid), 32'd1);
    check_val("ramp_word0", 32'(frame_data[0]), 32'h0000F800);
    check_val("ramp_word63", 32'(frame_data[63]), 32'h0000F83F);
    exp_q.push_back(ramp_frame(0, 1));
    handshake();
    check_val("ramp_count", 32'(frame_count), 32'd1);
    check_val("ramp_valid_after_hs", 32'(frame_valid), 32'd0);

    // Midscale and extremes
    strobe(2048);
    strobe(4095);
    strobe(0);
    for (int i = 3; i < N; i++) strobe(2048);
    check_val("ext_word0", 32'(frame_data[0]), 32'h00000000);
    check_val("ext_word1", 32'(frame_data[1]), 32'h000007FF);
    check_val("ext_word2", 32'(frame_data[2]), 32'h0000F800);
    f = '0;
    f[16 +: 16] = 16'h07FF;
    f[32 +: 16] = 16'hF800;
    exp_q.push_back(f);
    handshake();
    check_val("ext_count", 32'(frame_count), 32'd2);

    // Back-pressure and overrun
    do_reset();
    for (int i = 0; i < 2 * N; i++) strobe(i);
    check_val("bp_overrun_before", 32'(overrun), 32'd0);
    check_val("bp_wr_state_stall", 32'(wr_state), 32'(W_STALL));
    strobe(2 * N);
    check_val("bp_overrun_after", 32'(overrun), 32'd1);
    strobe(2 * N + 1);
    check_frame("bp_bank0_unchanged", frame_data, ramp_frame(0, 1));
    exp_q.push_back(ramp_frame(0, 1));
    exp_q.push_back(ramp_frame(64, 1));
    handshake();
    check_val("bp_count1", 32'(frame_count), 32'd1);
    check_val("bp_valid_bank1", 32'(frame_valid), 32'd1);
    check_val("bp_bank1_word0", 32'(frame_data[0]), 32'h0000F840);
    check_val("bp_wr_state_fill", 32'(wr_state), 32'(W_FILL));
    handshake();
    check_val("bp_count2", 32'(frame_count), 32'd2);
    check_val("bp_overrun_sticky", 32'(overrun), 32'd1);

    // Handshake on the same edge as the bank-completing write
    do_reset();
    for (int i = 0; i < 2 * N - 1; i++) strobe(i);
    exp_q.push_back(ramp_frame(0, 1));
    mic_valid   = 1'b1;
    mic_data    = 12'(2 * N - 1);
    frame_ready = 1'b1;
    tick();
    mic_valid   = 1'b0;
    frame_ready = 1'b0;
    check_val("sim_count", 32'(frame_count), 32'd1);
    check_val("sim_valid", 32'(frame_valid), 32'd1);
    check_val("sim_overrun", 32'(overrun), 32'd0);
    check_frame("sim_bank1", frame_data, ramp_frame(64, 1));
    exp_q.push_back(ramp_frame(64, 1));
    handshake();

    // Reset mid-frame
    for (int i = 0; i < N; i++) strobe(500 + i);
    for (int i = 0; i < 30; i++) strobe(i);
    check_val("rst_pre_valid", 32'(frame_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("rst_async_valid", 32'(frame_valid), 32'd0);
    check_val("rst_async_count", 32'(frame_count), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) strobe(1000 + i);
    check_val("rst_fresh_valid", 32'(frame_valid), 32'd1);
    exp_q.push_back(ramp_frame(1000, 1));
    handshake();
    check_val("rst_fresh_count", 32'(frame_count), 32'd1);

    // Decimation by 4
    for (int i = 0; i < 4 * N - 1; i++) dstrobe(i);
    check_val("dec_valid_before", 32'(dframe_valid), 32'd0);
    dstrobe(4 * N - 1);
    check_val("dec_valid_after", 32'(dframe_valid), 32'd1);
    exp_dec_q.push_back(ramp_frame(3, 4));
    dframe_ready = 1'b1;
    tick();
    dframe_ready = 1'b0;
    check_val("dec_count", 32'(dframe_count), 32'd1);

    tick();
    check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check_val("exp_dec_q_drained", 32'(exp_dec_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
